dac_update_sequencer: RTL and testbench
=======================================

Name: dac_update_sequencer

Overview:
Downstream stage of the DPLL PID/filter, feeding the DAC SPI master (SPI_Master_With_Single_CS, TX count 2).
- Converts each signed PID correction into a clamped, slew-limited 16-bit DAC code.
- Sends the code as two bytes, MSB first, over the SPI master's byte handshake.
- Replaces the free-running byte counter that currently drives the DAC. Lives in the CLOCK_50 domain.

Parameters:
DAC_MID, 16'h8000, code emitted out of reset and the zero-correction point
CODE_MIN, 16'h0000, lowest code ever emitted
CODE_MAX, 16'hFFFF, highest code ever emitted
GAIN_SHIFT, 0, arithmetic right shift applied to pid_in (0..8)
MAX_STEP, 16'd256, maximum code change per update; 0 disables slew limit

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
i_pid_valid  in  1  one-cycle strobe, i_pid_out valid (already synchronised to CLOCK_50)
i_pid_out  in  16  signed PID correction
i_manual  in  1  1 = use i_manual_code, bypass gain and slew limit
i_manual_code  in  16  unsigned manual DAC code
i_TX_Ready  in  1  SPI master ready
o_TX_Byte  out  8  byte to SPI master
o_TX_DV  out  1  one-cycle byte-valid pulse
o_dac_code  out  16  last code fully sent
o_busy  out  1  transfer in progress
o_update_done  out  1  one-cycle pulse after second byte accepted
o_sat  out  1  last computed code was clamped or slew-limited
o_drop_count  out  8  saturating count of overwritten pending requests

Behaviour:
- Reset, all synchronous on CLOCK_50, values:
  - state IDLE
  - o_dac_code = last_code = DAC_MID
  - o_TX_Byte 0, o_TX_DV 0, o_busy 0, o_update_done 0, o_sat 0
  - o_drop_count 0, pending flag 0
- Reset mid-transfer aborts immediately with no further DV. The top level ties the SPI master i_Rst_L = ~reset so both blocks reset together.
- Request capture:
  - i_pid_valid in any state latches i_pid_out into the pending register and sets pending.
  - If pending is already set when a new strobe arrives, the sample is overwritten (latest wins) and o_drop_count increments, saturating at 255.
  - A strobe in the same cycle as a CALC consume counts as a new pending request, not a drop.
- Arithmetic, in CALC:
  - scaled = sign-extend(pending) >>> GAIN_SHIFT, 18-bit signed.
  - target = DAC_MID + scaled, 18-bit signed. Clamp to [CODE_MIN, CODE_MAX].
  - If MAX_STEP != 0 and |target - last_code| > MAX_STEP, code = last_code ± MAX_STEP.
  - Manual mode: code = i_manual_code clamped to [CODE_MIN, CODE_MAX]; no slew limit.
  - o_sat = 1 if any clamp or limit changed the value, else 0.
- FSM:
  - IDLE: if pending or i_manual → CALC.
    - In manual mode a request is generated only when i_manual_code != last_code.
  - CALC (1 cycle): compute code, clear pending, o_busy=1 → SEND_HI.
  - SEND_HI: wait for i_TX_Ready=1; then o_TX_Byte=code[15:8], o_TX_DV=1 for one cycle → GAP_HI.
  - GAP_HI (1 cycle): ignore i_TX_Ready, since it is registered in the master → SEND_LO.
  - SEND_LO: wait for i_TX_Ready=1; then o_TX_Byte=code[7:0], o_TX_DV=1 → GAP_LO.
  - GAP_LO (1 cycle) → WAIT_DONE.
  - WAIT_DONE: on i_TX_Ready=1, last_code=o_dac_code=code, o_update_done=1 for one cycle, o_busy=0 → IDLE.
- o_TX_Byte holds its value until the next DV.
- Latency: with i_TX_Ready held high, the first DV occurs 2 cycles after i_pid_valid.
- o_TX_DV is never asserted while i_TX_Ready=0.

Decomposition:
- Shared package dpll_pkg: FSM state encoding, DAC code width (16), PID width (16), and default DAC_MID/MAX_STEP constants shared with the PID block.
- One natural sub-module: dac_code_limiter, combinational. It performs shift, offset, clamp and slew limit and produces code and sat, so the arithmetic can be unit-tested separately.

Test Plan:
- Reset, then pid_out=0 strobe, MAX_STEP=256, ready high → bytes 0x80 then 0x00; o_dac_code=0x8000; o_sat=0; o_update_done once.
- last_code 0x8000, pid_out=+1000 → code 0x8100, o_sat=1. Repeat the strobe 4 times → codes 0x8200, 0x8300, 0x83E8; then stable.
- pid_out=-32768, MAX_STEP=0, CODE_MIN=16'h1000 → code 0x1000, bytes 0x10, 0x00, o_sat=1.
- Three strobes while SEND_HI is stalled (ready low) → the first transfer completes, then exactly one more update using the third value; o_drop_count=1.
- i_manual=1, i_manual_code=0x1234 → one transfer of 0x12, 0x34. Code held → no further transfers.
- Reset asserted in GAP_HI → no further DV, o_busy=0, o_dac_code=0x8000 the cycle after reset.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: DAC/PID widths, default DAC constants, sequencer FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpll_pkg;

  localparam int DAC_W = 16;
  localparam int PID_W = 16;

  // Defaults shared with the PID block so both agree on the zero-correction code
  localparam logic [DAC_W-1:0] DAC_MID_DEFAULT  = 16'h8000;
  localparam logic [DAC_W-1:0] MAX_STEP_DEFAULT = 16'd256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEND_HI,
    ST_GAP_HI,
    ST_SEND_LO,
    ST_GAP_LO,
    ST_WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/dac_update_sequencer_if.sv
// Bundle of the PID request side, manual override and SPI byte handshake of the DAC sequencer.
// Latency: n/a (wiring only).
// Backpressure: i_TX_Ready from the SPI master throttles o_TX_DV.
interface dac_update_sequencer_if;
  import dpll_pkg::*;

  logic             i_pid_valid;
  logic [PID_W-1:0] i_pid_out;
  logic             i_manual;
  logic [DAC_W-1:0] i_manual_code;
  logic             i_TX_Ready;
  logic [7:0]       o_TX_Byte;
  logic             o_TX_DV;
  logic [DAC_W-1:0] o_dac_code;
  logic             o_busy;
  logic             o_update_done;
  logic             o_sat;
  logic [7:0]       o_drop_count;

  // Sequencer side
  modport master (
    input  i_pid_valid, i_pid_out, i_manual, i_manual_code, i_TX_Ready,
    output o_TX_Byte, o_TX_DV, o_dac_code, o_busy, o_update_done, o_sat, o_drop_count
  );

  // Environment side (PID block, manual control, SPI master)
  modport slave (
    output i_pid_valid, i_pid_out, i_manual, i_manual_code, i_TX_Ready,
    input  o_TX_Byte, o_TX_DV, o_dac_code, o_busy, o_update_done, o_sat, o_drop_count
  );

endinterface

// File: rtl/dac_code_limiter.sv
// Turns a signed PID correction (or a manual code) into a clamped, slew-limited DAC code.
// Latency: combinational.
// Backpressure: none.
module dac_code_limiter
  import dpll_pkg::*;
#(
  parameter logic [DAC_W-1:0] DAC_MID    = DAC_MID_DEFAULT,
  parameter logic [DAC_W-1:0] CODE_MIN   = 16'h0000,
  parameter logic [DAC_W-1:0] CODE_MAX   = 16'hFFFF,
  parameter int unsigned      GAIN_SHIFT = 0,
  parameter logic [DAC_W-1:0] MAX_STEP   = MAX_STEP_DEFAULT
) (
  input  logic [PID_W-1:0] pid,
  input  logic             manual,
  input  logic [DAC_W-1:0] manual_code,
  input  logic [DAC_W-1:0] last_code,
  output logic [DAC_W-1:0] code,
  output logic             sat
);

  logic signed [17:0] scaled;
  logic signed [17:0] target;
  logic signed [17:0] diff;
  logic signed [17:0] step_s;
  logic [DAC_W-1:0]   clamped;
  logic               clamp_hit;
  logic               limit_hit;

  // Shift, offset, clamp, then slew-limit against the last code actually sent
  always_comb begin
    scaled = $signed({{2{pid[PID_W-1]}}, pid}) >>> GAIN_SHIFT;
    if (manual) target = $signed({2'b00, manual_code});
    else        target = $signed({2'b00, DAC_MID}) + scaled;

    if (target < $signed({2'b00, CODE_MIN}))      clamped = CODE_MIN;
    else if (target > $signed({2'b00, CODE_MAX})) clamped = CODE_MAX;
    else                                          clamped = target[DAC_W-1:0];
    clamp_hit = ($signed({2'b00, clamped}) != target);

    diff      = $signed({2'b00, clamped}) - $signed({2'b00, last_code});
    step_s    = $signed({2'b00, MAX_STEP});
    code      = clamped;
    limit_hit = 1'b0;
    // Manual codes bypass the slew limit so an operator can jump directly
    if (!manual && (MAX_STEP != '0)) begin
      if (diff > step_s) begin
        code      = last_code + MAX_STEP;
        limit_hit = 1'b1;
      end else if (diff < -step_s) begin
        code      = last_code - MAX_STEP;
        limit_hit = 1'b1;
      end
    end
    sat = clamp_hit | limit_hit;
  end

endmodule

// File: rtl/dac_update_sequencer.sv
// Captures PID corrections, computes a limited DAC code and ships it MSB-first as two SPI bytes.
// Latency: first o_TX_DV 2 cycles after i_pid_valid when i_TX_Ready is held high.
// Backpressure: waits on i_TX_Ready per byte; new requests during a transfer overwrite the pending one.
module dac_update_sequencer
  import dpll_pkg::*;
#(
  parameter logic [DAC_W-1:0] DAC_MID    = DAC_MID_DEFAULT,
  parameter logic [DAC_W-1:0] CODE_MIN   = 16'h0000,
  parameter logic [DAC_W-1:0] CODE_MAX   = 16'hFFFF,
  parameter int unsigned      GAIN_SHIFT = 0,
  parameter logic [DAC_W-1:0] MAX_STEP   = MAX_STEP_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  dac_update_sequencer_if.master bus
);

  seq_state_t       state, state_nxt;
  logic             pending;
  logic [PID_W-1:0] pend_dat;
  logic [DAC_W-1:0] last_code;
  logic [DAC_W-1:0] code_r;
  logic [DAC_W-1:0] lim_code;
  logic             lim_sat;
  logic             manual_req;
  logic             req;
  logic             tx_dv_r, tx_dv_nxt;
  logic [7:0]       tx_byte_r, tx_byte_nxt;
  logic             done_r;
  logic             sat_r;
  logic [7:0]       drop_r;
  logic             load_code;
  logic             commit;

  dac_code_limiter #(
    .DAC_MID   (DAC_MID),
    .CODE_MIN  (CODE_MIN),
    .CODE_MAX  (CODE_MAX),
    .GAIN_SHIFT(GAIN_SHIFT),
    .MAX_STEP  (MAX_STEP)
  ) u_limiter (
    .pid        (pend_dat),
    .manual     (bus.i_manual),
    .manual_code(bus.i_manual_code),
    .last_code  (last_code),
    .code       (lim_code),
    .sat        (lim_sat)
  );

  // Manual mode only asks for a transfer when the (clamped) code differs from what the DAC holds.
  // A strobe arriving in IDLE jumps straight to CALC since pend_dat is loaded on the same edge.
  assign manual_req = bus.i_manual && (lim_code != last_code);
  assign req        = pending || bus.i_pid_valid || manual_req;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; the GAP states skip one cycle because the master's ready is registered
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (req) state_nxt = ST_CALC;
      ST_CALC:      state_nxt = ST_SEND_HI;
      ST_SEND_HI:   if (bus.i_TX_Ready) state_nxt = ST_GAP_HI;
      ST_GAP_HI:    state_nxt = ST_SEND_LO;
      ST_SEND_LO:   if (bus.i_TX_Ready) state_nxt = ST_GAP_LO;
      ST_GAP_LO:    state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.i_TX_Ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: byte strobes, code capture and completion
  always_comb begin
    tx_dv_nxt   = ((state == ST_SEND_HI) || (state == ST_SEND_LO)) && bus.i_TX_Ready;
    tx_byte_nxt = (state == ST_SEND_HI) ? code_r[15:8] : code_r[7:0];
    load_code   = (state == ST_CALC);
    commit      = (state == ST_WAIT_DONE) && bus.i_TX_Ready;
  end

  // Transfer datapath: registered byte/DV, computed code, committed code and status
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_dv_r   <= 1'b0;
      tx_byte_r <= '0;
      done_r    <= 1'b0;
      sat_r     <= 1'b0;
      code_r    <= DAC_MID;
      last_code <= DAC_MID;
    end else begin
      tx_dv_r <= tx_dv_nxt;
      if (tx_dv_nxt) tx_byte_r <= tx_byte_nxt;
      done_r <= commit;
      if (load_code) begin
        code_r <= lim_code;
        sat_r  <= lim_sat;
      end
      if (commit) last_code <= code_r;
    end
  end

  // Request capture: latest sample wins; a strobe coinciding with CALC is a fresh request, not a drop
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_dat <= '0;
      drop_r   <= '0;
    end else if (bus.i_pid_valid) begin
      pend_dat <= bus.i_pid_out;
      pending  <= 1'b1;
      if (pending && !load_code && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
    end else if (load_code) begin
      pending <= 1'b0;
    end
  end

  assign bus.o_TX_Byte     = tx_byte_r;
  assign bus.o_TX_DV       = tx_dv_r;
  assign bus.o_dac_code    = last_code;
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_update_done = done_r;
  assign bus.o_sat         = sat_r;
  assign bus.o_drop_count  = drop_r;

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Randomized bench for dac_update_sequencer against a rule-level code model.
// Two instances: default limits, and one with slew limit off and a raised floor.
// A simple SPI-master model drops ready for a few cycles after each accepted byte.
module tb_dac_update_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  dac_update_sequencer_if bus_a ();
  dac_update_sequencer_if bus_b ();

  dac_update_sequencer dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus_a)
  );

  dac_update_sequencer #(
    .CODE_MIN(16'h1000),
    .MAX_STEP(16'd0)
  ) dut_b (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI master models: ready falls for lat cycles after each accepted byte
  int       cnt_a = 0, cnt_b = 0, lat_a = 2;
  bit       hold_a = 1'b0;
  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int       done_cnt = 0, dv_cnt = 0;

  assign bus_a.i_TX_Ready = (cnt_a == 0) && !hold_a;
  assign bus_b.i_TX_Ready = (cnt_b == 0);

  always @(posedge clk) begin
    if (bus_a.o_TX_DV && bus_a.i_TX_Ready) begin
      bytes_a.push_back(bus_a.o_TX_Byte);
      cnt_a <= lat_a;
    end else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (bus_b.o_TX_DV && bus_b.i_TX_Ready) begin
      bytes_b.push_back(bus_b.o_TX_Byte);
      cnt_b <= 2;
    end else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    if (bus_a.o_update_done) done_cnt <= done_cnt + 1;
    if (bus_a.o_TX_DV) dv_cnt <= dv_cnt + 1;
  end

  // A byte strobe must only appear while the master is ready
  always @(negedge clk) begin
    if (bus_a.o_TX_DV) check("dv_while_not_ready", bus_a.i_TX_Ready, 1'b1);
  end

  // Reference: expected code and saturation flag from the conversion rules
  function automatic void ref_code(input logic [15:0] pid, input bit man, input logic [15:0] mc,
                                   input int last, input int cmin, input int cmax, input int step,
                                   output int code, output bit sat);
    int t;
    if (man) t = int'(mc);
    else     t = 32768 + int'($signed(pid));
    code = (t < cmin) ? cmin : (t > cmax) ? cmax : t;
    sat  = (code != t);
    if (!man && step != 0) begin
      if (code - last > step) begin
        code = last + step;
        sat  = 1'b1;
      end else if (last - code > step) begin
        code = last - step;
        sat  = 1'b1;
      end
    end
  endfunction

  int last_m = 32'h8000;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] p);
    bus_a.i_pid_out   = p;
    bus_a.i_pid_valid = 1'b1;
    @(negedge clk);
    bus_a.i_pid_valid = 1'b0;
  endtask

  // Wait for the next completed update on instance A and check it against the model
  task automatic expect_update(input string tag, input logic [15:0] pid, input bit man,
                               input logic [15:0] mc);
    int         n = 0;
    int         ec;
    bit         es;
    logic [15:0] ecv;
    logic [7:0]  hi, lo;
    ref_code(pid, man, mc, last_m, 0, 16'hFFFF, 256, ec, es);
    ecv = ec[15:0];
    while (!bus_a.o_update_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 400), 1);
    check({tag, "_nbytes"}, bytes_a.size(), 2);
    hi = 8'h00; lo = 8'h00;
    if (bytes_a.size() >= 2) begin
      hi = bytes_a.pop_front();
      lo = bytes_a.pop_front();
    end
    check({tag, "_hi"}, hi, ecv[15:8]);
    check({tag, "_lo"}, lo, ecv[7:0]);
    check({tag, "_code"}, bus_a.o_dac_code, ecv);
    check({tag, "_sat"}, bus_a.o_sat, es);
    check({tag, "_busy"}, bus_a.o_busy, 1'b0);
    last_m = ec;
    @(negedge clk);
    check({tag, "_done_pulse"}, bus_a.o_update_done, 1'b0);
  endtask

  initial begin
    int          lat, n, d0;
    logic [15:0] p, p3, mc;

    bus_a.i_pid_valid = 0; bus_a.i_pid_out = 0; bus_a.i_manual = 0; bus_a.i_manual_code = 0;
    bus_b.i_pid_valid = 0; bus_b.i_pid_out = 0; bus_b.i_manual = 0; bus_b.i_manual_code = 0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_code", bus_a.o_dac_code, 16'h8000);
    check("rst_dv", bus_a.o_TX_DV, 1'b0);
    check("rst_byte", bus_a.o_TX_Byte, 8'h00);
    check("rst_busy", bus_a.o_busy, 1'b0);
    check("rst_done", bus_a.o_update_done, 1'b0);
    check("rst_sat", bus_a.o_sat, 1'b0);
    check("rst_drop", bus_a.o_drop_count, 8'h00);

    // Zero correction, with first-byte latency measured
    strobe(16'h0000);
    lat = 0;
    while (!bus_a.o_TX_DV && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
    d0 = done_cnt;
    expect_update("zero", 16'h0000, 0, 0);
    check("zero_done_once", done_cnt - d0, 1);

    // Large positive step gets slewed 256 per update until it reaches the target, then holds
    for (int i = 0; i < 5; i++) begin
      strobe(16'd1000);
      expect_update("slew", 16'd1000, 0, 0);
    end
    check("slew_final", bus_a.o_dac_code, 16'h83E8);

    // Three strobes during a stalled first byte: one drop, then one more update with the third
    hold_a = 1'b1;
    p  = 16'(last_m - 32768 + 100);
    p3 = 16'hFF00;
    strobe(p);
    tick(4);
    strobe(16'h0123);
    tick(1);
    strobe(p3);
    check("drop_count", bus_a.o_drop_count, 8'd1);
    check("drop_busy", bus_a.o_busy, 1'b1);
    hold_a = 1'b0;
    d0 = done_cnt;
    expect_update("drop_first", p, 0, 0);
    expect_update("drop_third", p3, 0, 0);
    tick(30);
    check("drop_no_more", done_cnt - d0, 2);

    // Manual code: one transfer, then nothing while the code is held
    for (int i = 0; i < 2; i++) begin
      mc = (i == 0) ? 16'h1234 : 16'($urandom);
      if (mc == last_m[15:0]) mc = mc ^ 16'h0001;
      bus_a.i_manual_code = mc;
      bus_a.i_manual      = 1'b1;
      d0 = done_cnt;
      expect_update("manual", 0, 1, mc);
      tick(40);
      check("manual_held", done_cnt - d0, 1);
    end
    bus_a.i_manual = 1'b0;
    tick(2);

    // Random corrections with random master latency
    for (int i = 0; i < 30; i++) begin
      lat_a = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) p = 16'($urandom);
      else                           p = 16'(last_m - 32768 + $urandom_range(0, 1200) - 600);
      strobe(p);
      expect_update("rand", p, 0, 0);
    end
    check("drop_total", bus_a.o_drop_count, 8'd1);

    // Floor clamp with slew limit disabled
    bus_b.i_pid_out   = 16'h8000;
    bus_b.i_pid_valid = 1'b1;
    @(negedge clk);
    bus_b.i_pid_valid = 1'b0;
    n = 0;
    while (!bus_b.o_update_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("floor_timeout", 32'(n < 200), 1);
    check("floor_nbytes", bytes_b.size(), 2);
    if (bytes_b.size() >= 2) begin
      check("floor_hi", bytes_b.pop_front(), 8'h10);
      check("floor_lo", bytes_b.pop_front(), 8'h00);
    end
    check("floor_code", bus_b.o_dac_code, 16'h1000);
    check("floor_sat", bus_b.o_sat, 1'b1);

    // Reset while the first byte is in flight
    lat_a = 2;
    tick(5);
    strobe(16'h0400);
    n = 0;
    while (!bus_a.o_TX_DV && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gap_reach", 32'(n < 20), 1);
    reset = 1'b1;
    @(negedge clk);
    check("gap_rst_dv", bus_a.o_TX_DV, 1'b0);
    check("gap_rst_busy", bus_a.o_busy, 1'b0);
    check("gap_rst_code", bus_a.o_dac_code, 16'h8000);
    check("gap_rst_drop", bus_a.o_drop_count, 8'h00);
    check("gap_rst_sat", bus_a.o_sat, 1'b0);
    d0 = dv_cnt;
    tick(1);
    reset = 1'b0;
    tick(20);
    check("gap_no_dv", dv_cnt - d0, 0);
    check("gap_idle", bus_a.o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
